// File: rtl/multicycle_mem_responder_pkg.sv
// Shared types and constants for the multicycle memory responder.
package multicycle_mem_responder_pkg;

  // Transaction FSM: accept -> optional wait states -> single SRAM cycle -> response.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } mc_state_e;

  // Largest wait-state count the 4-bit counter can express.
  localparam int MC_MEM_WAIT_MAX = 15;

endpackage

// File: rtl/multicycle_mem_responder.sv
// Multicycle SRAM responder: accepts one read or write at a time, inserts
// WAIT_STATES idle cycles, performs a single SRAM cycle, then pulses a response.
// Requests that assert both read and write are answered with an error and no
// SRAM access.
// Optional feature: define MEM_RANGE_CHECK_EN to reject addresses whose bits
// above ADDR_WIDTH are non-zero (error response, no SRAM access). Without it
// the upper address bits simply alias.
module multicycle_mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_byte_en,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [31:0]           sram_wdata,
  output logic [3:0]            sram_wmask,
  output logic                  sram_re,
  output logic                  sram_we,
  input  logic [31:0]           sram_rdata
);
  import multicycle_mem_responder_pkg::*;

  // Out-of-range parameter values saturate at what the counter can hold.
  localparam int WS_EFF = (WAIT_STATES > MC_MEM_WAIT_MAX) ? MC_MEM_WAIT_MAX :
                          (WAIT_STATES < 0) ? 0 : WAIT_STATES;
  localparam logic [3:0] WAIT_INIT = (WS_EFF > 0) ? 4'(WS_EFF - 1) : 4'd0;

  mc_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  is_rd_q, is_rd_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  range_err;

  // Only [ADDR_WIDTH-1:2] reach the SRAM; the rest feed the optional range check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // Address range check on the incoming request.
`ifdef MEM_RANGE_CHECK_EN
  assign range_err = ((req_addr >> ADDR_WIDTH) != 32'd0);
`else
  assign range_err = 1'b0;
`endif

  // State and latched request registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and output decode. SRAM strobes and address are forced to zero
  // outside ACCESS so reset and idle both present a quiet SRAM port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_rd_d    = is_rd_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    resp_rdata = rdata_q;
    sram_addr  = '0;
    sram_wdata = 32'd0;
    sram_wmask = 4'd0;
    sram_re    = 1'b0;
    sram_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_read && req_write) begin
          // Ambiguous request: answer with an error, never touch the SRAM.
          is_rd_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else if (req_read || req_write) begin
          addr_d  = req_addr[ADDR_WIDTH-1:2];
          wdata_d = req_wdata;
          be_d    = req_byte_en;
          is_rd_d = req_read;
          err_d   = range_err;
          if (range_err) begin
            state_d = ST_RESPOND;
          end else if (WS_EFF > 0) begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACCESS: begin
        sram_addr = addr_q;
        if (is_rd_q) begin
          sram_re = 1'b1;
        end else begin
          sram_we    = 1'b1;
          sram_wmask = be_q;
          sram_wdata = wdata_q;
        end
        state_d = ST_RESPOND;
      end

      ST_RESPOND: begin
        // sram_rdata is valid this cycle (one after sram_re); pass it through
        // and keep a copy so resp_rdata holds until the next response.
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (is_rd_q && !err_q) ? sram_rdata : 32'd0;
        rdata_d    = resp_rdata;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Scoreboard bench for multicycle_mem_responder: a WAIT_STATES=1 instance for
// the main directed vectors and a WAIT_STATES=0 instance for back-to-back reads.
// Each instance talks to a behavioural SRAM with one-cycle read latency.
module tb_multicycle_mem_responder;
  localparam int AW = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  exp_t sb[$];
  exp_t sb0[$];

  // ---------------- DUT with one wait state ----------------
  logic        req_read = 0, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_byte_en = 0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata, sram_wdata, sram_rdata;
  logic [AW-3:0] sram_addr;
  logic [3:0]  sram_wmask;
  logic        sram_re, sram_we;
  logic [31:0] mem [0:(1<<(AW-2))-1];

  multicycle_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
    .sram_re(sram_re), .sram_we(sram_we), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: byte-masked write, registered read.
  always @(posedge clock) begin
    if (sram_re) sram_rdata <= mem[sram_addr];
    if (sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
  end

  // ---------------- DUT with zero wait states ----------------
  logic        req_read_0 = 0;
  logic [31:0] req_addr_0 = 0;
  logic        req_ready_0, resp_valid_0, resp_error_0;
  logic [31:0] resp_rdata_0, sram_wdata_0, sram_rdata_0;
  logic [AW-3:0] sram_addr_0;
  logic [3:0]  sram_wmask_0;
  logic        sram_re_0, sram_we_0;
  logic [31:0] mem0 [0:(1<<(AW-2))-1];

  multicycle_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_read(req_read_0), .req_write(1'b0), .req_addr(req_addr_0),
    .req_wdata(32'd0), .req_byte_en(4'd0), .req_ready(req_ready_0),
    .resp_valid(resp_valid_0), .resp_rdata(resp_rdata_0), .resp_error(resp_error_0),
    .sram_addr(sram_addr_0), .sram_wdata(sram_wdata_0), .sram_wmask(sram_wmask_0),
    .sram_re(sram_re_0), .sram_we(sram_we_0), .sram_rdata(sram_rdata_0)
  );

  always @(posedge clock) begin
    if (sram_re_0) sram_rdata_0 <= mem0[sram_addr_0];
    if (sram_we_0)
      for (int b = 0; b < 4; b++)
        if (sram_wmask_0[b]) mem0[sram_addr_0][b*8 +: 8] <= sram_wdata_0[b*8 +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears, and watches the
  // SRAM strobes of the main instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (sram_re && sram_we) chk("strobe_overlap", {sram_re, sram_we}, 2'b00);
        if (sram_re || sram_we) strobes++;
        if (resp_valid) begin
          if (sb.size() == 0) chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
          else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            chk("resp_cycle", cyc, e.cyc);
          end
        end
        if (resp_valid_0) begin
          if (sb0.size() == 0) chk("unexpected_resp0", {31'd0, resp_valid_0}, 32'd0);
          else begin
            e = sb0.pop_front();
            chk("resp0_rdata", resp_rdata_0, e.rdata);
            chk("resp0_error", {31'd0, resp_error_0}, {31'd0, e.err});
            chk("resp0_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  // Issue one request to the main instance; expectation goes to the scoreboard
  // with the response cycle = accept-cycle count + latency.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] er, input logic ee, input int lat,
                       input bit push);
    int n = 0;
    @(negedge clock);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_byte_en = be;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    if (push) sb.push_back('{er, ee, cyc + lat});
    @(posedge clock); #1;
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_byte_en = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sb0.size() != 0) && n < 40) begin @(negedge clock); n++; end
    if (sb.size() != 0 || sb0.size() != 0) chk("drain_timeout", sb.size() + sb0.size(), 0);
    @(negedge clock);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_sram_re_we"}, {30'd0, sram_re, sram_we}, 32'd0);
    chk({tag, "_sram_wmask"}, {28'd0, sram_wmask}, 32'd0);
    chk({tag, "_sram_addr"}, {{(32-(AW-2)){1'b0}}, sram_addr}, 32'd0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    for (int i = 0; i < (1<<(AW-2)); i++) begin mem[i] = 32'd0; mem0[i] = 32'd0; end
    mem0[5] = 32'hCAFE0005;
    sram_rdata = 32'd0;
    sram_rdata_0 = 32'd0;

    #12;
    chk_quiet("reset");
    @(negedge clock); reset_n = 1'b1;

    // Full write then read-back, 3-cycle latency each.
    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 3, 1);
    drain();
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1);
    drain();
    repeat (3) @(negedge clock);
    chk("rdata_hold", resp_rdata, 32'hDEADBEEF);

    // Byte-lane merge.
    issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 3, 1);
    issue(0, 1, 32'h20, 32'h000000AA, 4'h1, 32'h0, 0, 3, 1);
    issue(1, 0, 32'h22, 32'h0, 4'h0, 32'h112233AA, 0, 3, 1);
    drain();

    // Empty mask: still a write strobe, memory untouched.
    s0 = strobes;
    issue(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 3, 1);
    drain();
    chk("empty_mask_strobe", strobes, s0 + 1);
    issue(1, 0, 32'h20, 32'h0, 4'h0, 32'h112233AA, 0, 3, 1);
    drain();

    // Read+write together: error, no SRAM activity, 1-cycle latency.
    s0 = strobes;
    issue(1, 1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1, 1, 1);
    drain();
    chk("rw_err_no_strobe", strobes, s0);

    // Upper address bits.
    issue(0, 1, 32'h0, 32'h55667788, 4'hF, 32'h0, 0, 3, 1);
    drain();
    s0 = strobes;
`ifdef MEM_RANGE_CHECK_EN
    issue(1, 0, 32'h00010000, 32'h0, 4'h0, 32'h0, 1, 1, 1);
    drain();
    chk("range_no_strobe", strobes, s0);
`else
    issue(1, 0, 32'h00010000, 32'h0, 4'h0, 32'h55667788, 0, 3, 1);
    drain();
    chk("alias_strobe", strobes, s0 + 1);
`endif

    // Reset during WAIT aborts the read.
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_quiet("midreset");
    @(negedge clock); reset_n = 1'b1;
    repeat (6) @(negedge clock);
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1);
    drain();

    // Zero wait states, read held high: re-accept the cycle after RESPOND.
    @(negedge clock);
    n = cyc;
    req_read_0 = 1; req_addr_0 = 32'h14;
    sb0.push_back('{32'hCAFE0005, 1'b0, n + 2});
    sb0.push_back('{32'hCAFE0005, 1'b0, n + 5});
    chk("b2b_ready_n0", {31'd0, req_ready_0}, 32'd1);
    @(negedge clock); chk("b2b_ready_n1", {31'd0, req_ready_0}, 32'd0);
    @(negedge clock); chk("b2b_ready_n2", {31'd0, req_ready_0}, 32'd0);
    @(negedge clock); chk("b2b_ready_n3", {31'd0, req_ready_0}, 32'd1);
    @(negedge clock); req_read_0 = 0;
    drain();
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
